// File: rtl/ultrasonido_pkg.sv
// Shared state encoding, constants and output decode for the ultrasonic measurement sequencer.
package ultrasonido_pkg;

    localparam int DIST_W    = 9;
    localparam int US_PER_CM = 58;
    localparam logic [DIST_W-1:0] DIST_ERR = 9'h1FF;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CLEAR     = 3'd1;
    localparam logic [2:0] TRIG      = 3'd2;
    localparam logic [2:0] WAIT_ECHO = 3'd3;
    localparam logic [2:0] MEASURE   = 3'd4;
    localparam logic [2:0] LATCH     = 3'd5;
    localparam logic [2:0] TOUT      = 3'd6;
    localparam logic [2:0] HOLDOFF   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = IDLE,
        S_CLEAR     = CLEAR,
        S_TRIG      = TRIG,
        S_WAIT_ECHO = WAIT_ECHO,
        S_MEASURE   = MEASURE,
        S_LATCH     = LATCH,
        S_TOUT      = TOUT,
        S_HOLDOFF   = HOLDOFF
    } state_t;

    typedef struct packed {
        logic clear;
        logic trigger;
        logic enable;
        logic busy;
    } ctl_t;

    // Control levels that belong to a state; loaded together with the state register.
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c.clear   = (s == S_CLEAR);
        c.trigger = (s == S_TRIG);
        c.enable  = (s == S_WAIT_ECHO) || (s == S_MEASURE);
        c.busy    = (s != S_IDLE);
        return c;
    endfunction

endpackage

// File: rtl/ultrasonido_tick_us.sv
// Microsecond prescaler: one-cycle tick every DIV clocks, restartable so the
// first tick after a restart lands exactly DIV clocks after the restart cycle.
module ultrasonido_tick_us #(
    parameter int DIV = 100
) (
    input  logic Clock,
    input  logic Reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    // The restart cycle itself is clock 0 of the new microsecond.
    assign tick = !restart && (cnt == CW'(DIV - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CW'(1);
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ultrasonido_control.sv
// Ultrasonic measurement sequencer: trigger, counter clear/enable, echo supervision,
// result capture and re-trigger holdoff. Define ULTRASONIDO_AUTO_EN for free-running mode.
module ultrasonido_control
    import ultrasonido_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int PERIOD_US   = 60000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Echo,
    input  logic       Done_in,
    input  logic [8:0] Distancia_in,
    output logic       Trigger,
    output logic       Clear,
    output logic       Enable,
    output logic [8:0] Distancia,
    output logic       Valid,
    output logic       Error,
    output logic       Busy
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int TW  = $clog2(PERIOD_US + 1);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_US - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_US - 1);
    localparam logic [TW-1:0] PERIOD_T  = TW'(PERIOD_US);

    state_t        state;
    state_t        state_q;
    ctl_t          ctl;
    logic          echo_m, echo_s, echo_q;
    logic          done_m, done_s;
    logic          echo_rise, echo_fall;
    logic          fell, fall_rst;
    logic          entry, restart, tick, go;
    logic [TW-1:0] st_cnt, per_cnt;

`ifdef ULTRASONIDO_AUTO_EN
    assign go = 1'b1 | Start;
`else
    assign go = Start;
`endif

    assign entry     = (state != state_q);
    assign restart   = entry | fall_rst;
    assign echo_rise = echo_s & ~echo_q;
    assign echo_fall = ~echo_s & echo_q;

    assign Clear   = ctl.clear;
    assign Trigger = ctl.trigger;
    assign Enable  = ctl.enable;
    assign Busy    = ctl.busy;

    ultrasonido_tick_us #(.DIV(DIV)) u_tick (
        .Clock   (Clock),
        .Reset   (Reset),
        .restart (restart),
        .tick    (tick)
    );

    // Synchronisers, entry detection and the two microsecond counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            echo_m   <= 1'b0;
            echo_s   <= 1'b0;
            echo_q   <= 1'b0;
            done_m   <= 1'b0;
            done_s   <= 1'b0;
            state_q  <= S_IDLE;
            fell     <= 1'b0;
            fall_rst <= 1'b0;
            st_cnt   <= '0;
            per_cnt  <= '0;
        end else begin
            echo_m   <= Echo;
            echo_s   <= echo_m;
            echo_q   <= echo_s;
            done_m   <= Done_in;
            done_s   <= done_m;
            state_q  <= state;
            fall_rst <= (state == S_MEASURE) && !fell && echo_fall;
            fell     <= (state == S_MEASURE) && (fell || echo_fall);

            if (restart) begin
                st_cnt <= '0;
            end else if (tick && st_cnt != '1) begin
                st_cnt <= st_cnt + 1'b1;
            end

            // The re-trigger period is measured from the start of the trigger pulse.
            if (entry && state == S_TRIG) begin
                per_cnt <= '0;
            end else if (tick && per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            ctl       <= '0;
            Distancia <= '0;
            Error     <= 1'b0;
            Valid     <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_CLEAR;
                        ctl   <= ctl_of(S_CLEAR);
                    end
                end
                S_CLEAR: begin
                    state <= S_TRIG;
                    ctl   <= ctl_of(S_TRIG);
                end
                S_TRIG: begin
                    if (tick && st_cnt == TRIG_LAST) begin
                        state <= S_WAIT_ECHO;
                        ctl   <= ctl_of(S_WAIT_ECHO);
                    end
                end
                S_WAIT_ECHO: begin
                    if (echo_rise) begin
                        state <= S_MEASURE;
                        ctl   <= ctl_of(S_MEASURE);
                    end else if (tick && st_cnt == TOUT_LAST) begin
                        state <= S_TOUT;
                        ctl   <= ctl_of(S_TOUT);
                    end
                end
                S_MEASURE: begin
                    // After the echo falls st_cnt counts ticks since the fall instead.
                    if (done_s) begin
                        state <= S_LATCH;
                        ctl   <= ctl_of(S_LATCH);
                    end else if (fell && tick && st_cnt == TW'(1)) begin
                        state <= S_LATCH;
                        ctl   <= ctl_of(S_LATCH);
                    end else if (!fell && tick && st_cnt == TOUT_LAST) begin
                        state <= S_TOUT;
                        ctl   <= ctl_of(S_TOUT);
                    end
                end
                S_LATCH: begin
                    Distancia <= Distancia_in;
                    Error     <= 1'b0;
                    Valid     <= 1'b1;
                    state     <= S_HOLDOFF;
                    ctl       <= ctl_of(S_HOLDOFF);
                end
                S_TOUT: begin
                    Distancia <= DIST_ERR;
                    Error     <= 1'b1;
                    Valid     <= 1'b1;
                    state     <= S_HOLDOFF;
                    ctl       <= ctl_of(S_HOLDOFF);
                end
                S_HOLDOFF: begin
                    if (per_cnt >= PERIOD_T) begin
                        state <= S_IDLE;
                        ctl   <= ctl_of(S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= ctl_of(S_IDLE);
                end
            endcase
        end
    end

endmodule
